// File: rtl/serial_add_arb_pkg.sv
// Shared types and constants for the two-requester nibble-serial adder.
package serial_add_arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit4adder.sv
// 4-bit ripple adder with carry in/out; the shared nibble datapath.
module bit4adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/serial_add_arb.sv
// Two-requester round-robin front end feeding a nibble-serial adder:
// one WIDTH-bit add per NIB+2 cycles through a single 4-bit adder.
module serial_add_arb
    import serial_add_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_id
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("serial_add_arb: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry;
    logic               cout_r;
    logic               id_r;
    logic               last_gnt;
    logic [IDX_W-1:0]   idx;
    logic [NREQ-1:0]    gnt;
    logic               gnt_id;
    logic [3:0]         nib_sum;
    logic               nib_cout;

    // Grant is suppressed while reset is held so no requester sees an accept that reset discards.
    always_comb begin
        gnt = '0;
        if (rst_n && state == ST_IDLE) begin
            if (req_valid == 2'b11) begin
                gnt = last_gnt ? 2'b01 : 2'b10;
            end else begin
                gnt = req_valid;
            end
        end
    end

    assign gnt_id    = gnt[1];
    assign req_ready = gnt;

    bit4adder u_nib_add (
        .a    (a_r[4*int'(idx) +: 4]),
        .b    (b_r[4*int'(idx) +: 4]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            cout_r    <= 1'b0;
            id_r      <= 1'b0;
            last_gnt  <= 1'b1;
            idx       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        a_r      <= gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        b_r      <= gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        carry    <= gnt_id ? req_cin[1] : req_cin[0];
                        id_r     <= gnt_id;
                        last_gnt <= gnt_id;
                        idx      <= '0;
                        cout_r   <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r[4*int'(idx) +: 4] <= nib_sum;
                    carry <= nib_cout;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(NIB - 1)) begin
                        cout_r    <= nib_cout;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_sum  = sum_r;
    assign rsp_cout = cout_r;
    assign rsp_id   = id_r;

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed bench for serial_add_arb: vector table plus arbitration, backpressure and reset sequences.
module tb_serial_add_arb;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add_arb #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges from the cycle after the accept until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        @(negedge clk);
        req_valid = 2'b00;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_add(input string tag, input vec_t v);
        int lat;
        @(negedge clk);
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_cin[v.id]      = v.cin;
        req_valid          = 2'b00;
        req_valid[v.id]    = 1'b1;
        rsp_ready          = 1'b1;
        #1 chk({tag, ".ready"}, 32'(req_ready), 32'(1) << v.id);
        wait_rsp(lat);
        chk({tag, ".latency"}, 32'(lat), 32'd5);
        chk({tag, ".sum"},     32'(rsp_sum), 32'(v.sum));
        chk({tag, ".cout"},    32'(rsp_cout), 32'(v.cout));
        chk({tag, ".id"},      32'(rsp_id), 32'(v.id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, ng, nr;
        vec_t v;

        vecs[0] = '{0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
        vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{1, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[6] = '{0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        // Reset with both requesters asserting.
        rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_sum",   32'(rsp_sum),   32'd0);
        chk("reset.rsp_cout",  32'(rsp_cout),  32'd0);
        chk("reset.rsp_id",    32'(rsp_id),    32'd0);
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_add($sformatf("vec%0d", i), vecs[i]);
        end

        // Contention right after reset: grants alternate 0,1,0,1 every 6 cycles.
        @(negedge clk);
        rst_n = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_a = {16'h0100, 16'h0001};
        req_b = {16'h0200, 16'h0002};
        req_cin = 2'b00;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        ng = 0; nr = 0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != 2'b00) begin
                chk($sformatf("rr.grant%0d", ng), 32'(req_ready), (ng % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("rr.cycle%0d", ng), 32'(c), 32'(ng * 6));
                ng++;
            end
            if (rsp_valid) begin
                chk($sformatf("rr.id%0d", nr),  32'(rsp_id),  32'(nr % 2));
                chk($sformatf("rr.sum%0d", nr), 32'(rsp_sum), (nr % 2 == 0) ? 32'h0003 : 32'h0300);
                nr++;
            end
        end
        chk("rr.grants",    32'(ng), 32'd4);
        chk("rr.responses", 32'(nr), 32'd4);

        // Backpressure: hold DONE for 10 cycles while both requesters assert.
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_a[W +: W] = 16'h7FFF; req_b[W +: W] = 16'h0001; req_cin[1] = 1'b0;
        req_valid = 2'b10;
        #1 chk("bp.ready", 32'(req_ready), 32'd2);
        wait_rsp(lat);
        chk("bp.latency", 32'(lat), 32'd5);
        req_a = {16'h5555, 16'h1111};
        req_b = {16'h5555, 16'h2222};
        req_cin = 2'b01;
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("bp.hold%0d", i), {13'd0, rsp_valid, rsp_cout, rsp_id, rsp_sum},
                {13'd0, 1'b1, 1'b0, 1'b1, 16'h8000});
            chk($sformatf("bp.ready%0d", i), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp.complete_valid", 32'(rsp_valid), 32'd1);
        chk("bp.complete_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("bp.idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp.idle_grant", 32'(req_ready), 32'd1);

        // That grant to requester 0 is now in RUN; reset it two cycles in.
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_a[0 +: W] = 16'h0FF0; req_b[0 +: W] = 16'h0010; req_cin[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_run.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_run.rsp_sum",   32'(rsp_sum),   32'd0);
        chk("rst_run.rsp_cout",  32'(rsp_cout),  32'd0);
        chk("rst_run.rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_run.req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1 chk("rst_run.first_tie", 32'(req_ready), 32'd1);
        wait_rsp(lat);
        chk("rst_run.latency", 32'(lat), 32'd5);
        chk("rst_run.sum",     32'(rsp_sum), 32'h1000);
        chk("rst_run.id",      32'(rsp_id),  32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; WIDTH SHALL be a multiple of 4 and at least 4, otherwise elaboration SHALL fail.
REQ-002 SHALL derive local constant NIB = WIDTH/4, the number of nibble steps per add.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready, output, 2, per-requester accept strobe.
REQ-007 SHALL have port req_a, input, 2*WIDTH, operand A per requester (slice i = requester i).
REQ-008 SHALL have port req_b, input, 2*WIDTH, operand B per requester.
REQ-009 SHALL have port req_cin, input, 2, carry-in per requester.
REQ-010 SHALL have port rsp_valid, output, 1, result valid.
REQ-011 SHALL have port rsp_ready, input, 1, result consumer ready.
REQ-012 SHALL have port rsp_sum, output, WIDTH, A+B+cin modulo 2^WIDTH.
REQ-013 SHALL have port rsp_cout, output, 1, carry out of the top nibble.
REQ-014 SHALL have port rsp_id, output, 1, index of the requester that owns the result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE, if any req_valid is high, SHALL grant exactly one requester, assert only that bit of req_ready in the same cycle (combinational from req_valid and state), latch its a, b, cin and id, clear the nibble index, and move to RUN.
REQ-017 SHALL drive req_ready to 0 in every state other than IDLE.
REQ-018 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last. When only one is valid, grant that one.
REQ-019 In RUN, each cycle SHALL add nibble k of the latched A and B with the carry register through the shared 4-bit adder, store the sum into nibble k, update the carry register, and increment k.
REQ-020 After the step with k = NIB-1, SHALL move to DONE. The carry register then becomes rsp_cout.
REQ-021 In DONE, SHALL hold rsp_valid high with rsp_sum, rsp_cout and rsp_id stable until rsp_ready is high, then return to IDLE.
REQ-022 Latency: for a handshake in cycle T, rsp_valid SHALL first be high in cycle T+NIB+1 (T+5 for WIDTH 16).
REQ-023 The earliest next accept SHALL be the cycle after the rsp handshake, giving a throughput of one add per NIB+2 cycles.
REQ-024 req_valid changes while the block is in RUN or DONE SHALL have no effect. A requester may drop valid before being granted.
REQ-025 Overflow SHALL wrap: the sum is taken modulo 2^WIDTH and the overflow appears only on rsp_cout.

Reset
REQ-026 When rst_n is low at a clock edge, SHALL enter IDLE, drive rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0 and req_ready=0, clear the carry register and index, and set the last-grant pointer to 1 so requester 0 wins the first tie.
REQ-027 Reset mid-RUN or mid-DONE SHALL discard the operation in progress with no response.

Structure
REQ-028 The state enum and the requester-count constant (2) SHALL live in a shared package. WIDTH SHALL stay a module parameter.
REQ-029 SHALL instantiate exactly one existing bit4adder as the shared nibble datapath. All sequencing, arbitration and registers SHALL be in serial_add_arb.

Verification
REQ-030 Single add: req0 with a=0x1234, b=0x0FFF, cin=0 -> req_ready=01 in cycle 0, rsp_valid in cycle 5, sum=0x2233, cout=0, id=0.
REQ-031 Wrap: req1 with a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, id=1. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-032 Contention: both requesters valid continuously -> grants alternate 0,1,0,1 after reset, with one accept per 6 cycles while rsp_ready=1.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles in DONE -> outputs held stable, req_ready stays 00, completion occurs on the first cycle rsp_ready=1, and IDLE is entered on the next cycle.
REQ-034 Reset in RUN: assert rst_n=0 in cycle T+2 -> the next cycle shows all outputs at reset values, no response for the aborted op, and the first post-reset tie is granted to requester 0.
